// File: rtl/vdp_pkg.sv
// Shared definitions for the VDP video-RAM block.
//   VRAM_SIZE_DEF : default VRAM depth in bytes
//   vdp_state_e   : CPU data-port sequencer states
package vdp_pkg;

    localparam int VRAM_SIZE_DEF = 8 * 1024;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_PEND = 2'd1,
        RD_PEND = 2'd2
    } vdp_state_e;

endpackage

// File: rtl/vdp_vram.sv
// Single-port byte-wide VRAM with a synchronous write and a registered read.
// Ports:
//   clk   : clock
//   en    : port enable; a read or write happens only when set
//   we    : write enable (with en); otherwise a read is performed
//   addr  : byte address
//   wdata : write byte
//   rdata : read byte, valid the cycle after an enabled read
module vdp_vram #(
    parameter int SIZE = 8 * 1024,
    parameter int AW   = $clog2(SIZE)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] mem [SIZE];

    // rdata only moves on an enabled read, so a write never disturbs it.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= wdata;
            else    rdata     <= mem[addr];
        end
    end

endmodule

// File: rtl/vdp_vram_port.sv
// VRAM arbiter: a video read port with absolute priority, plus a CPU data port
// with an auto-incrementing address pointer, one write latch and a read-ahead
// buffer. CPU operations wait for a cycle with no video read.
// Ports:
//   pxclk, reset_n        : clock, asynchronous active-low reset
//   vdp_dma_addr/_rd_tick : video read request; vram_dout returns the byte
//   cpu_addr_ld_tick      : load pointer from cpu_addr; cpu_addr_rd prefetches
//   cpu_wr_tick/_wr_data  : write byte to mem[ptr], ptr+1
//   cpu_rd_tick           : consume cpu_rd_data, fetch mem[ptr], ptr+1
//   cpu_busy              : a CPU operation is pending
//   cpu_overrun           : one-cycle pulse after a CPU tick was dropped
module vdp_vram_port
    import vdp_pkg::*;
#(
    parameter int VRAM_SIZE       = VRAM_SIZE_DEF,
    parameter int VRAM_ADDR_WIDTH = $clog2(VRAM_SIZE)
) (
    input  logic                       pxclk,
    input  logic                       reset_n,
    input  logic [VRAM_ADDR_WIDTH-1:0] vdp_dma_addr,
    input  logic                       vdp_dma_rd_tick,
    output logic [7:0]                 vram_dout,
    input  logic                       cpu_addr_ld_tick,
    input  logic [VRAM_ADDR_WIDTH-1:0] cpu_addr,
    input  logic                       cpu_addr_rd,
    input  logic                       cpu_wr_tick,
    input  logic [7:0]                 cpu_wr_data,
    input  logic                       cpu_rd_tick,
    output logic [7:0]                 cpu_rd_data,
    output logic                       cpu_busy,
    output logic                       cpu_overrun
);

    localparam int AW = VRAM_ADDR_WIDTH;

    vdp_state_e    state;
    logic [AW-1:0] ptr;
    logic [AW-1:0] ptr_next;
    logic [7:0]    wr_latch;
    logic          rd_issued;   // RD_PEND: RAM read already launched
    logic          dma_d1;      // RAM rdata this cycle belongs to video
    logic [7:0]    dout_hold;

    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_rdata;

    logic          any_tick;
    logic          multi_tick;

    assign ptr_next   = (ptr == AW'(VRAM_SIZE - 1)) ? '0 : ptr + 1'b1;
    assign cpu_busy   = (state != IDLE);
    assign any_tick   = cpu_addr_ld_tick | cpu_wr_tick | cpu_rd_tick;
    assign multi_tick = (cpu_addr_ld_tick & (cpu_wr_tick | cpu_rd_tick)) |
                        (cpu_wr_tick & cpu_rd_tick);

    // Video owns the port whenever it asks; the CPU only gets idle cycles.
    always_comb begin
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = ptr;
        if (vdp_dma_rd_tick) begin
            ram_en   = 1'b1;
            ram_addr = vdp_dma_addr;
        end else if (state == WR_PEND) begin
            ram_en = 1'b1;
            ram_we = 1'b1;
        end else if (state == RD_PEND && !rd_issued) begin
            ram_en = 1'b1;
        end
    end

    vdp_vram #(
        .SIZE (VRAM_SIZE),
        .AW   (AW)
    ) u_vram (
        .clk   (pxclk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wr_latch),
        .rdata (ram_rdata)
    );

    // Video data is forwarded straight from the RAM register in the return
    // cycle, then held so later CPU reads cannot disturb it.
    assign vram_dout = dma_d1 ? ram_rdata : dout_hold;

    always_ff @(posedge pxclk or negedge reset_n) begin
        if (!reset_n) begin
            dma_d1    <= 1'b0;
            dout_hold <= 8'h00;
        end else begin
            dma_d1 <= vdp_dma_rd_tick;
            if (dma_d1) dout_hold <= ram_rdata;
        end
    end

    always_ff @(posedge pxclk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            ptr         <= '0;
            wr_latch    <= 8'h00;
            rd_issued   <= 1'b0;
            cpu_rd_data <= 8'h00;
            cpu_overrun <= 1'b0;
        end else begin
            cpu_overrun <= cpu_busy ? any_tick : multi_tick;
            case (state)
                IDLE: begin
                    rd_issued <= 1'b0;
                    if (cpu_addr_ld_tick) begin
                        ptr   <= cpu_addr;
                        state <= cpu_addr_rd ? RD_PEND : IDLE;
                    end else if (cpu_wr_tick) begin
                        wr_latch <= cpu_wr_data;
                        state    <= WR_PEND;
                    end else if (cpu_rd_tick) begin
                        state <= RD_PEND;
                    end
                end
                WR_PEND: begin
                    if (!vdp_dma_rd_tick) begin
                        ptr   <= ptr_next;
                        state <= IDLE;
                    end
                end
                RD_PEND: begin
                    // rdata here is from the read launched last cycle, even if
                    // video has taken the port this cycle.
                    if (rd_issued) begin
                        cpu_rd_data <= ram_rdata;
                        ptr         <= ptr_next;
                        rd_issued   <= 1'b0;
                        state       <= IDLE;
                    end else if (!vdp_dma_rd_tick) begin
                        rd_issued <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vdp_vram_port.sv
module tb_vdp_vram_port;

    localparam int AW = 13;

    logic          pxclk;
    logic          reset_n;
    logic [AW-1:0] vdp_dma_addr;
    logic          vdp_dma_rd_tick;
    logic [7:0]    vram_dout;
    logic          cpu_addr_ld_tick;
    logic [AW-1:0] cpu_addr;
    logic          cpu_addr_rd;
    logic          cpu_wr_tick;
    logic [7:0]    cpu_wr_data;
    logic          cpu_rd_tick;
    logic [7:0]    cpu_rd_data;
    logic          cpu_busy;
    logic          cpu_overrun;

    int n_checks = 0;
    int n_fail   = 0;

    vdp_vram_port dut (
        .pxclk            (pxclk),
        .reset_n          (reset_n),
        .vdp_dma_addr     (vdp_dma_addr),
        .vdp_dma_rd_tick  (vdp_dma_rd_tick),
        .vram_dout        (vram_dout),
        .cpu_addr_ld_tick (cpu_addr_ld_tick),
        .cpu_addr         (cpu_addr),
        .cpu_addr_rd      (cpu_addr_rd),
        .cpu_wr_tick      (cpu_wr_tick),
        .cpu_wr_data      (cpu_wr_data),
        .cpu_rd_tick      (cpu_rd_tick),
        .cpu_rd_data      (cpu_rd_data),
        .cpu_busy         (cpu_busy),
        .cpu_overrun      (cpu_overrun)
    );

    initial pxclk = 1'b0;
    always #20 pxclk = ~pxclk;

    task automatic cyc();
        @(posedge pxclk);
        #1;
    endtask

    task automatic load(input logic [AW-1:0] a);
        cpu_addr_ld_tick = 1'b1; cpu_addr = a; cpu_addr_rd = 1'b0;
        cyc();
        cpu_addr_ld_tick = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d);
        cpu_wr_tick = 1'b1; cpu_wr_data = d;
        cyc();
        cpu_wr_tick = 1'b0;
        cyc();
    endtask

    task automatic dma_read(input logic [AW-1:0] a);
        vdp_dma_rd_tick = 1'b1; vdp_dma_addr = a;
        cyc();
        vdp_dma_rd_tick = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        vdp_dma_addr = '0; vdp_dma_rd_tick = 1'b0;
        cpu_addr_ld_tick = 1'b0; cpu_addr = '0; cpu_addr_rd = 1'b0;
        cpu_wr_tick = 1'b0; cpu_wr_data = 8'h00; cpu_rd_tick = 1'b0;
        cyc(); cyc();
        reset_n = 1'b1;
        cyc();
        n_checks++; if (vram_dout !== 8'h00) begin n_fail++; $display("FAIL reset_vram_dout got %h exp 00", vram_dout); end
        n_checks++; if (cpu_rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_cpu_rd_data got %h exp 00", cpu_rd_data); end
        n_checks++; if (cpu_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", cpu_busy); end
        n_checks++; if (cpu_overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b exp 0", cpu_overrun); end
        n_checks++; if (dut.ptr !== 13'h0000) begin n_fail++; $display("FAIL reset_ptr got %h exp 0000", dut.ptr); end
    endtask

    task automatic test_write();
        load(13'h1000);
        n_checks++; if (dut.ptr !== 13'h1000) begin n_fail++; $display("FAIL wr_load_ptr got %h exp 1000", dut.ptr); end
        n_checks++; if (cpu_busy !== 1'b0) begin n_fail++; $display("FAIL wr_load_busy got %b exp 0", cpu_busy); end
        cpu_wr_tick = 1'b1; cpu_wr_data = 8'hA5;
        cyc();
        cpu_wr_tick = 1'b0;
        n_checks++; if (cpu_busy !== 1'b1) begin n_fail++; $display("FAIL wr_busy_on got %b exp 1", cpu_busy); end
        cyc();
        n_checks++; if (cpu_busy !== 1'b0) begin n_fail++; $display("FAIL wr_busy_off got %b exp 0", cpu_busy); end
        n_checks++; if (dut.ptr !== 13'h1001) begin n_fail++; $display("FAIL wr_ptr got %h exp 1001", dut.ptr); end
        dma_read(13'h1000);
        n_checks++; if (vram_dout !== 8'hA5) begin n_fail++; $display("FAIL wr_dma_data got %h exp a5", vram_dout); end
        cyc();
        n_checks++; if (vram_dout !== 8'hA5) begin n_fail++; $display("FAIL wr_dma_hold got %h exp a5", vram_dout); end
    endtask

    task automatic test_read();
        load(13'h0200);
        write_byte(8'h3C);
        write_byte(8'h77);
        cpu_addr_ld_tick = 1'b1; cpu_addr = 13'h0200; cpu_addr_rd = 1'b1;
        cyc();
        cpu_addr_ld_tick = 1'b0; cpu_addr_rd = 1'b0;
        n_checks++; if (cpu_busy !== 1'b1) begin n_fail++; $display("FAIL rd_busy_c0 got %b exp 1", cpu_busy); end
        cyc();
        n_checks++; if (cpu_busy !== 1'b1) begin n_fail++; $display("FAIL rd_busy_c1 got %b exp 1", cpu_busy); end
        n_checks++; if (cpu_rd_data !== 8'h00) begin n_fail++; $display("FAIL rd_early_data got %h exp 00", cpu_rd_data); end
        cyc();
        n_checks++; if (cpu_busy !== 1'b0) begin n_fail++; $display("FAIL rd_busy_c2 got %b exp 0", cpu_busy); end
        n_checks++; if (cpu_rd_data !== 8'h3C) begin n_fail++; $display("FAIL rd_prefetch got %h exp 3c", cpu_rd_data); end
        n_checks++; if (dut.ptr !== 13'h0201) begin n_fail++; $display("FAIL rd_prefetch_ptr got %h exp 0201", dut.ptr); end
        cpu_rd_tick = 1'b1;
        cyc();
        cpu_rd_tick = 1'b0;
        n_checks++; if (cpu_rd_data !== 8'h3C) begin n_fail++; $display("FAIL rd_tick_hold got %h exp 3c", cpu_rd_data); end
        cyc(); cyc();
        n_checks++; if (cpu_rd_data !== 8'h77) begin n_fail++; $display("FAIL rd_next got %h exp 77", cpu_rd_data); end
        n_checks++; if (dut.ptr !== 13'h0202) begin n_fail++; $display("FAIL rd_next_ptr got %h exp 0202", dut.ptr); end
    endtask

    task automatic test_dma_stall();
        logic [AW-1:0] addrs [5];
        logic [7:0]    exps  [5];
        addrs = '{13'h1000, 13'h0200, 13'h0201, 13'h1000, 13'h0201};
        exps  = '{8'hA5, 8'h3C, 8'h77, 8'hA5, 8'h77};
        load(13'h0300);
        cpu_wr_tick = 1'b1; cpu_wr_data = 8'h5A;
        cyc();
        cpu_wr_tick = 1'b0;
        for (int k = 0; k < 5; k++) begin
            vdp_dma_rd_tick = 1'b1; vdp_dma_addr = addrs[k];
            cyc();
            n_checks++; if (vram_dout !== exps[k]) begin n_fail++; $display("FAIL stall_dout[%0d] got %h exp %h", k, vram_dout, exps[k]); end
            n_checks++; if (cpu_busy !== 1'b1) begin n_fail++; $display("FAIL stall_busy[%0d] got %b exp 1", k, cpu_busy); end
        end
        vdp_dma_rd_tick = 1'b0;
        cyc();
        n_checks++; if (cpu_busy !== 1'b0) begin n_fail++; $display("FAIL stall_release got %b exp 0", cpu_busy); end
        n_checks++; if (vram_dout !== 8'h77) begin n_fail++; $display("FAIL stall_dout_hold got %h exp 77", vram_dout); end
        n_checks++; if (dut.ptr !== 13'h0301) begin n_fail++; $display("FAIL stall_ptr got %h exp 0301", dut.ptr); end
        dma_read(13'h0300);
        n_checks++; if (vram_dout !== 8'h5A) begin n_fail++; $display("FAIL stall_landed got %h exp 5a", vram_dout); end
    endtask

    task automatic test_wrap();
        load(13'h1FFF);
        write_byte(8'h11);
        n_checks++; if (dut.ptr !== 13'h0000) begin n_fail++; $display("FAIL wrap_ptr got %h exp 0000", dut.ptr); end
        dma_read(13'h1FFF);
        n_checks++; if (vram_dout !== 8'h11) begin n_fail++; $display("FAIL wrap_data got %h exp 11", vram_dout); end
    endtask

    task automatic test_overrun();
        cpu_wr_tick = 1'b1; cpu_rd_tick = 1'b1; cpu_wr_data = 8'h22;
        cyc();
        cpu_rd_tick = 1'b0;
        cpu_wr_data = 8'h99;
        n_checks++; if (cpu_busy !== 1'b1) begin n_fail++; $display("FAIL ovr_busy got %b exp 1", cpu_busy); end
        n_checks++; if (cpu_overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_coincide got %b exp 1", cpu_overrun); end
        cyc();
        cpu_wr_tick = 1'b0;
        n_checks++; if (cpu_overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_busy_drop got %b exp 1", cpu_overrun); end
        n_checks++; if (cpu_busy !== 1'b0) begin n_fail++; $display("FAIL ovr_done got %b exp 0", cpu_busy); end
        n_checks++; if (dut.ptr !== 13'h0001) begin n_fail++; $display("FAIL ovr_ptr got %h exp 0001", dut.ptr); end
        cyc();
        n_checks++; if (cpu_overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_pulse_end got %b exp 0", cpu_overrun); end
        n_checks++; if (cpu_rd_data !== 8'h77) begin n_fail++; $display("FAIL ovr_rd_data got %h exp 77", cpu_rd_data); end
        dma_read(13'h0000);
        n_checks++; if (vram_dout !== 8'h22) begin n_fail++; $display("FAIL ovr_mem got %h exp 22", vram_dout); end
    endtask

    task automatic test_reset_mid();
        load(13'h0400);
        write_byte(8'h44);
        load(13'h0400);
        cpu_wr_tick = 1'b1; cpu_wr_data = 8'hEE;
        cyc();
        cpu_wr_tick = 1'b0;
        n_checks++; if (cpu_busy !== 1'b1) begin n_fail++; $display("FAIL rst_pending got %b exp 1", cpu_busy); end
        reset_n = 1'b0;
        #1;
        n_checks++; if (cpu_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", cpu_busy); end
        n_checks++; if (vram_dout !== 8'h00) begin n_fail++; $display("FAIL rst_dout got %h exp 00", vram_dout); end
        n_checks++; if (cpu_rd_data !== 8'h00) begin n_fail++; $display("FAIL rst_rd_data got %h exp 00", cpu_rd_data); end
        cyc();
        reset_n = 1'b1;
        cyc();
        n_checks++; if (dut.ptr !== 13'h0000) begin n_fail++; $display("FAIL rst_ptr got %h exp 0000", dut.ptr); end
        dma_read(13'h0400);
        n_checks++; if (vram_dout !== 8'h44) begin n_fail++; $display("FAIL rst_no_write got %h exp 44", vram_dout); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_dma_stall();
        test_wrap();
        test_overrun();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
